// File: rtl/cpu_stat_counter.sv
// ---------------------------------------------------------------------------
// cpu_stat_counter
//
// Performance-statistics unit for the pipelined MIPS CPU. It tracks the
// run/halt status of the CPU and counts, while running:
//   - executed cycles,
//   - retired unconditional jumps (j/jal/jr),
//   - taken conditional branches,
//   - inserted pipeline bubbles (stall or flush slots).
// Every counter saturates at MAX_COUNT so the downstream 8-digit BCD display
// never shows a wrapped value. The counters are plain unsigned binary.
//
// Parameters:
//   WIDTH      - width of every counter output
//   MAX_COUNT  - saturation ceiling of every counter
//
// Ports:
//   clk                 - system clock
//   rst                 - asynchronous active-high reset (state RUN, counts 0)
//   halt                - pulse: halt instruction retired in WB (RUN -> HALTED)
//   go                  - pulse: debounced run button (HALTED -> RUN)
//   clr                 - synchronous clear of all counters, state untouched
//   jmp_retire          - unconditional jump retired this cycle
//   br_taken            - conditional branch resolved taken this cycle
//   bubble              - pipeline bubble inserted this cycle
//   running             - high while in RUN; drives the pipeline enable
//   total_cycles        - cycles spent in RUN
//   uncondi_branch_num  - retired unconditional jumps
//   condi_branch_num    - taken conditional branches
//   bubble_num          - inserted bubbles
// ---------------------------------------------------------------------------
module cpu_stat_counter #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] MAX_COUNT = WIDTH'(99_999_999)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             go,
  input  logic             clr,
  input  logic             jmp_retire,
  input  logic             br_taken,
  input  logic             bubble,
  output logic             running,
  output logic [WIDTH-1:0] total_cycles,
  output logic [WIDTH-1:0] uncondi_branch_num,
  output logic [WIDTH-1:0] condi_branch_num,
  output logic [WIDTH-1:0] bubble_num
);

  // -------------------------------------------------------------------------
  // Run/halt FSM
  // -------------------------------------------------------------------------
  typedef enum logic [0:0] {
    StRun    = 1'b0,
    StHalted = 1'b1
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Only the input that can leave the current state is looked at, so a
  // simultaneous halt+go resolves to "halt" in RUN and "go" in HALTED.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (halt) state_d = StHalted;
      StHalted: if (go)   state_d = StRun;
    endcase
  end

  // Pure state decode: no combinational path from any input.
  always_comb begin
    running = (state_q == StRun);
  end

  // -------------------------------------------------------------------------
  // Saturating event counters
  // -------------------------------------------------------------------------
  localparam int unsigned NumCnt = 4;
  localparam int unsigned IdxTotal  = 0;
  localparam int unsigned IdxJump   = 1;
  localparam int unsigned IdxBranch = 2;
  localparam int unsigned IdxBubble = 3;

  logic [NumCnt-1:0] cnt_evt;
  logic [WIDTH-1:0]  cnt_q [NumCnt];
  logic [WIDTH-1:0]  cnt_d [NumCnt];

  // The cycle counter treats every RUN cycle as an event.
  always_comb begin
    cnt_evt            = '0;
    cnt_evt[IdxTotal]  = 1'b1;
    cnt_evt[IdxJump]   = jmp_retire;
    cnt_evt[IdxBranch] = br_taken;
    cnt_evt[IdxBubble] = bubble;
  end

  // Clear beats increment; increments only in RUN and only below the ceiling.
  // The "<" compare also pins a counter that somehow sits above the ceiling.
  always_comb begin
    for (int i = 0; i < NumCnt; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
      end else if (running && cnt_evt[i] && (cnt_q[i] < MAX_COUNT)) begin
        cnt_d[i] = cnt_q[i] + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumCnt; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumCnt; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    total_cycles       = cnt_q[IdxTotal];
    uncondi_branch_num = cnt_q[IdxJump];
    condi_branch_num   = cnt_q[IdxBranch];
    bubble_num         = cnt_q[IdxBubble];
  end

endmodule

// File: tb/tb_cpu_stat_counter.sv
module tb_cpu_stat_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halt = 1'b0, go = 1'b0, clr = 1'b0;
  logic jmp = 1'b0, br = 1'b0, bub = 1'b0;

  logic        run_m, run_s;
  logic [31:0] t_m, u_m, c_m, b_m;
  logic [31:0] t_s, u_s, c_s, b_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_stat_counter u_dut (
    .clk                (clk),
    .rst                (rst),
    .halt               (halt),
    .go                 (go),
    .clr                (clr),
    .jmp_retire         (jmp),
    .br_taken           (br),
    .bubble             (bub),
    .running            (run_m),
    .total_cycles       (t_m),
    .uncondi_branch_num (u_m),
    .condi_branch_num   (c_m),
    .bubble_num         (b_m)
  );

  // Small ceiling to exercise saturation quickly.
  cpu_stat_counter #(
    .WIDTH     (32),
    .MAX_COUNT (32'd5)
  ) u_sat (
    .clk                (clk),
    .rst                (rst),
    .halt               (halt),
    .go                 (go),
    .clr                (clr),
    .jmp_retire         (jmp),
    .br_taken           (br),
    .bubble             (bub),
    .running            (run_s),
    .total_cycles       (t_s),
    .uncondi_branch_num (u_s),
    .condi_branch_num   (c_s),
    .bubble_num         (b_s)
  );

  // Advance n active edges and land 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges (called at edge+1).
  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    total++;
    if (run_m !== 1'b1) begin
      bad++; $display("FAIL reset_running got=%b want=1", run_m);
    end
    total++;
    if ({t_m, u_m, c_m, b_m} !== 128'd0) begin
      bad++; $display("FAIL reset_counts got=%0d/%0d/%0d/%0d want=0/0/0/0", t_m, u_m, c_m, b_m);
    end
    total++;
    if ({run_s, t_s, b_s} !== {1'b1, 64'd0}) begin
      bad++; $display("FAIL reset_sat got=%b/%0d/%0d want=1/0/0", run_s, t_s, b_s);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle_run();
    step(10);
    total++;
    if (t_m !== 32'd10) begin
      bad++; $display("FAIL idle_total got=%0d want=10", t_m);
    end
    total++;
    if ({u_m, c_m, b_m} !== 96'd0) begin
      bad++; $display("FAIL idle_events got=%0d/%0d/%0d want=0/0/0", u_m, c_m, b_m);
    end
    total++;
    if (run_m !== 1'b1) begin
      bad++; $display("FAIL idle_running got=%b want=1", run_m);
    end
  endtask

  task automatic test_all_events();
    jmp = 1'b1; br = 1'b1; bub = 1'b1;
    step(3);
    jmp = 1'b0; br = 1'b0; bub = 1'b0;
    total++;
    if (u_m !== 32'd3) begin
      bad++; $display("FAIL events_jump got=%0d want=3", u_m);
    end
    total++;
    if (c_m !== 32'd3) begin
      bad++; $display("FAIL events_branch got=%0d want=3", c_m);
    end
    total++;
    if (b_m !== 32'd3) begin
      bad++; $display("FAIL events_bubble got=%0d want=3", b_m);
    end
    total++;
    if (t_m !== 32'd13) begin
      bad++; $display("FAIL events_total got=%0d want=13", t_m);
    end
  endtask

  task automatic test_halt_go();
    int low;
    do_reset();
    step(5);
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    total++;
    if ({run_m, t_m} !== {1'b0, 32'd6}) begin
      bad++; $display("FAIL halt_entry got=%b/%0d want=0/6", run_m, t_m);
    end
    low = (run_m == 1'b0) ? 1 : 0;
    // Events while halted must be ignored.
    jmp = 1'b1; br = 1'b1; bub = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (run_m == 1'b0) low++;
    end
    jmp = 1'b0; br = 1'b0; bub = 1'b0;
    // go together with halt while HALTED: go wins.
    go = 1'b1; halt = 1'b1;
    step(1);
    go = 1'b0; halt = 1'b0;
    total++;
    if (low !== 21) begin
      bad++; $display("FAIL halt_low_cycles got=%0d want=21", low);
    end
    total++;
    if ({run_m, t_m} !== {1'b1, 32'd6}) begin
      bad++; $display("FAIL halt_go_resume got=%b/%0d want=1/6", run_m, t_m);
    end
    total++;
    if ({u_m, c_m, b_m} !== 96'd0) begin
      bad++; $display("FAIL halt_ignored_events got=%0d/%0d/%0d want=0/0/0", u_m, c_m, b_m);
    end
    step(4);
    total++;
    if (t_m !== 32'd10) begin
      bad++; $display("FAIL halt_go_total got=%0d want=10", t_m);
    end
  endtask

  task automatic test_halt_priority();
    // halt together with go while RUN: halt wins, its cycle is counted.
    go = 1'b1; halt = 1'b1;
    step(1);
    go = 1'b0; halt = 1'b0;
    total++;
    if ({run_m, t_m} !== {1'b0, 32'd11}) begin
      bad++; $display("FAIL prio_halt_wins got=%b/%0d want=0/11", run_m, t_m);
    end
    go = 1'b1;
    step(1);
    go = 1'b0;
    total++;
    if ({run_m, t_m} !== {1'b1, 32'd11}) begin
      bad++; $display("FAIL prio_go_resume got=%b/%0d want=1/11", run_m, t_m);
    end
  endtask

  task automatic test_clr();
    bub = 1'b1;
    step(2);
    bub = 1'b0;
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    total++;
    if ({run_m, t_m, b_m} !== {1'b0, 32'd14, 32'd2}) begin
      bad++; $display("FAIL clr_setup got=%b/%0d/%0d want=0/14/2", run_m, t_m, b_m);
    end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(3);
    total++;
    if ({t_m, u_m, c_m, b_m} !== 128'd0) begin
      bad++; $display("FAIL clr_halted_counts got=%0d/%0d/%0d/%0d want=0/0/0/0", t_m, u_m, c_m, b_m);
    end
    total++;
    if (run_m !== 1'b0) begin
      bad++; $display("FAIL clr_halted_state got=%b want=0", run_m);
    end
    go = 1'b1;
    step(1);
    go = 1'b0;
    bub = 1'b1;
    step(2);
    bub = 1'b0;
    total++;
    if ({run_m, t_m, b_m} !== {1'b1, 32'd2, 32'd2}) begin
      bad++; $display("FAIL clr_resume got=%b/%0d/%0d want=1/2/2", run_m, t_m, b_m);
    end
    // clr beats simultaneous increments.
    clr = 1'b1; jmp = 1'b1; br = 1'b1; bub = 1'b1;
    step(1);
    clr = 1'b0; jmp = 1'b0; br = 1'b0; bub = 1'b0;
    total++;
    if ({t_m, u_m, c_m, b_m} !== 128'd0) begin
      bad++; $display("FAIL clr_priority got=%0d/%0d/%0d/%0d want=0/0/0/0", t_m, u_m, c_m, b_m);
    end
    bub = 1'b1;
    step(1);
    bub = 1'b0;
    clr = 1'b1; halt = 1'b1;
    step(1);
    clr = 1'b0; halt = 1'b0;
    total++;
    if ({run_m, t_m, b_m} !== {1'b0, 64'd0}) begin
      bad++; $display("FAIL clr_with_halt got=%b/%0d/%0d want=0/0/0", run_m, t_m, b_m);
    end
    go = 1'b1;
    step(1);
    go = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    bub = 1'b1;
    step(4);
    total++;
    if ({t_s, b_s} !== {32'd4, 32'd4}) begin
      bad++; $display("FAIL sat_below got=%0d/%0d want=4/4", t_s, b_s);
    end
    step(4);
    bub = 1'b0;
    total++;
    if (b_s !== 32'd5) begin
      bad++; $display("FAIL sat_bubble got=%0d want=5", b_s);
    end
    total++;
    if (t_s !== 32'd5) begin
      bad++; $display("FAIL sat_total got=%0d want=5", t_s);
    end
    total++;
    if ({u_s, c_s} !== 64'd0) begin
      bad++; $display("FAIL sat_idle got=%0d/%0d want=0/0", u_s, c_s);
    end
    total++;
    if ({t_m, b_m} !== {32'd8, 32'd8}) begin
      bad++; $display("FAIL sat_wide got=%0d/%0d want=8/8", t_m, b_m);
    end
  endtask

  task automatic test_async_reset();
    step(3);
    total++;
    if (t_m !== 32'd11) begin
      bad++; $display("FAIL areset_pre got=%0d want=11", t_m);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({run_m, t_m, b_m} !== {1'b1, 64'd0}) begin
      bad++; $display("FAIL areset_immediate got=%b/%0d/%0d want=1/0/0", run_m, t_m, b_m);
    end
    #2;
    rst = 1'b0;
    step(1);
    total++;
    if (t_m !== 32'd1) begin
      bad++; $display("FAIL areset_resume got=%0d want=1", t_m);
    end
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (run_m !== 1'b1) begin
      bad++; $display("FAIL areset_from_halt got=%b want=1", run_m);
    end
    #1;
    rst = 1'b0;
    step(2);
    total++;
    if ({run_m, t_m} !== {1'b1, 32'd2}) begin
      bad++; $display("FAIL areset_halt_resume got=%b/%0d want=1/2", run_m, t_m);
    end
  endtask

  initial begin
    test_reset();
    test_idle_run();
    test_all_events();
    test_halt_go();
    test_halt_priority();
    test_clr();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
